// File: rtl/colour_frame_ctrl_if.sv
// Signal bundle between the colour frame controller and its surroundings
// (detector count path, threshold return path, motion-logic flag).
interface colour_frame_ctrl_if;
  // No backpressure anywhere: sop qualifies red_pixels for exactly one cycle and
  // count_valid qualifies last_count for exactly one cycle; both are pulses.
  logic        enable;
  logic        sop;
  logic [16:0] red_pixels;
  logic        auto_en;
  logic [3:0]  thresh_manual;
  logic [3:0]  upper_thresh;
  logic        red_detected;
  logic        count_valid;
  logic [16:0] last_count;
  logic [7:0]  frame_cnt;
  logic [1:0]  fsm_state;

  modport master (
    output enable, sop, red_pixels, auto_en, thresh_manual,
    input  upper_thresh, red_detected, count_valid, last_count, frame_cnt, fsm_state
  );

  modport slave (
    input  enable, sop, red_pixels, auto_en, thresh_manual,
    output upper_thresh, red_detected, count_valid, last_count, frame_cnt, fsm_state
  );
endinterface

// File: rtl/colour_frame_ctrl.sv
// Frame-level controller: samples the red pixel count at each start-of-frame,
// debounces red_detected with hysteresis and steps the detector threshold on frame boundaries.
module colour_frame_ctrl #(
  parameter logic [16:0] HI_COUNT    = 17'd2000,
  parameter logic [16:0] LO_COUNT    = 17'd800,
  parameter int          N_CONFIRM   = 3,
  parameter logic [16:0] SAT_COUNT   = 17'd30000,
  parameter logic [16:0] MIN_COUNT   = 17'd200,
  parameter logic [3:0]  THRESH_MIN  = 4'd6,
  parameter logic [3:0]  THRESH_INIT = 4'd10
) (
  input logic               clk,
  input logic               reset,
  colour_frame_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    MEASURE = 2'd2,
    EVAL    = 2'd3
  } state_t;

  localparam logic [2:0] CONFIRM = 3'(N_CONFIRM);

  state_t      state;
  logic [3:0]  upper_thresh;
  logic [3:0]  pending;
  logic [3:0]  pend_auto;
  logic        red_detected;
  logic        count_valid;
  logic [16:0] last_count;
  logic [7:0]  frame_cnt;
  logic [2:0]  hit_run;
  logic [2:0]  miss_run;
  logic [2:0]  hit_inc;
  logic [2:0]  miss_inc;
  logic        is_hit;
  logic        is_miss;

  assign is_hit   = (last_count >= HI_COUNT);
  assign is_miss  = (last_count < LO_COUNT);
  assign hit_inc  = (hit_run == 3'd7) ? 3'd7 : hit_run + 3'd1;
  assign miss_inc = (miss_run == 3'd7) ? 3'd7 : miss_run + 3'd1;

  // In EVAL upper_thresh always equals the value applied at the sop, so it is
  // the correct base both in steady auto mode and right after leaving manual mode.
  always_comb begin
    pend_auto = upper_thresh;
    if (last_count > SAT_COUNT && upper_thresh != 4'd15)
      pend_auto = upper_thresh + 4'd1;
    else if (last_count < MIN_COUNT && upper_thresh > THRESH_MIN)
      pend_auto = upper_thresh - 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      upper_thresh <= THRESH_INIT;
      pending      <= THRESH_INIT;
      red_detected <= 1'b0;
      count_valid  <= 1'b0;
      last_count   <= 17'd0;
      frame_cnt    <= 8'd0;
      hit_run      <= 3'd0;
      miss_run     <= 3'd0;
    end else begin
      count_valid <= 1'b0;
      if (!bus.auto_en)
        pending <= bus.thresh_manual;
      if (!bus.enable) begin
        state    <= IDLE;
        hit_run  <= 3'd0;
        miss_run <= 3'd0;
      end else begin
        case (state)
          IDLE: state <= SYNC;
          SYNC: begin
            if (bus.sop) begin
              upper_thresh <= pending;
              state        <= MEASURE;
            end
          end
          MEASURE: begin
            if (bus.sop) begin
              last_count   <= bus.red_pixels;
              upper_thresh <= pending;
              state        <= EVAL;
            end
          end
          EVAL: begin
            count_valid <= 1'b1;
            frame_cnt   <= frame_cnt + 8'd1;
            if (is_hit) begin
              hit_run  <= hit_inc;
              miss_run <= 3'd0;
              if (hit_inc == CONFIRM)
                red_detected <= 1'b1;
            end else if (is_miss) begin
              miss_run <= miss_inc;
              hit_run  <= 3'd0;
              if (miss_inc == CONFIRM)
                red_detected <= 1'b0;
            end else begin
              hit_run  <= 3'd0;
              miss_run <= 3'd0;
            end
            if (bus.auto_en)
              pending <= pend_auto;
            state <= MEASURE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.upper_thresh = upper_thresh;
  assign bus.red_detected = red_detected;
  assign bus.count_valid  = count_valid;
  assign bus.last_count   = last_count;
  assign bus.frame_cnt    = frame_cnt;
  assign bus.fsm_state    = state;

endmodule

// File: tb/tb_colour_frame_ctrl.sv
// Bench for colour_frame_ctrl: directed frame table, disable/reset sequences and
// randomized frames checked against a frame-level reference model.
module tb_colour_frame_ctrl;

  localparam int HI = 2000, LO = 800, NCONF = 3, SAT = 30000, MINC = 200;
  localparam int TMIN = 6, TINIT = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  colour_frame_ctrl_if bus();

  colour_frame_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // frame-level reference model
  logic [3:0]  m_thresh, m_pend;
  logic        m_red;
  logic [16:0] m_last;
  logic [7:0]  m_frame;
  int          m_hit, m_miss;
  bit          m_sync;
  logic [16:0] exp_q[$];

  typedef struct {
    logic [16:0] count;
    logic        auto_en;
    logic [3:0]  manual;
    logic        valid;
    logic [7:0]  frame;
    logic        red;
    logic [3:0]  thresh;
  } vec_t;
  vec_t tbl[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_thresh = 4'(TINIT);
    m_pend   = 4'(TINIT);
    m_red    = 1'b0;
    m_last   = 17'd0;
    m_frame  = 8'd0;
    m_hit    = 0;
    m_miss   = 0;
    m_sync   = 1'b1;
    exp_q.delete();
  endtask

  task automatic model_sop(input logic [16:0] c, output bit acc);
    acc    = !m_sync;
    m_sync = 1'b0;
    if (!bus.auto_en) m_pend = bus.thresh_manual;
    m_thresh = m_pend;
    if (acc) begin
      m_last  = c;
      m_frame = m_frame + 8'd1;
      exp_q.push_back(c);
      if (int'(c) >= HI) begin
        m_hit  = (m_hit < 7) ? m_hit + 1 : 7;
        m_miss = 0;
        if (m_hit == NCONF) m_red = 1'b1;
      end else if (int'(c) < LO) begin
        m_miss = (m_miss < 7) ? m_miss + 1 : 7;
        m_hit  = 0;
        if (m_miss == NCONF) m_red = 1'b0;
      end else begin
        m_hit  = 0;
        m_miss = 0;
      end
      if (bus.auto_en) begin
        if (int'(c) > SAT && m_thresh < 4'd15) m_pend = m_thresh + 4'd1;
        else if (int'(c) < MINC && int'(m_thresh) > TMIN) m_pend = m_thresh - 4'd1;
      end
    end
  endtask

  // Waits pre cycles, pulses sop with count c, and checks the two following cycles.
  task automatic send_frame(input logic [16:0] c, input int pre, output logic o_valid,
                            output logic [7:0] o_frame, output logic o_red, output logic [3:0] o_thresh);
    bit acc;
    logic [16:0] e;
    repeat (pre) @(negedge clk);
    check("thresh_hold", bus.upper_thresh, m_thresh);
    bus.sop = 1'b1;
    bus.red_pixels = c;
    model_sop(c, acc);
    @(negedge clk);
    bus.sop = 1'b0;
    bus.red_pixels = 17'($urandom);
    check("thresh_apply", bus.upper_thresh, m_thresh);
    check("valid_early", bus.count_valid, 1'b0);
    o_thresh = bus.upper_thresh;
    @(negedge clk);
    check("count_valid", bus.count_valid, acc);
    if (acc && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("last_count", bus.last_count, e);
    end
    check("frame_cnt", bus.frame_cnt, m_frame);
    check("red_detected", bus.red_detected, m_red);
    o_valid = bus.count_valid;
    o_frame = bus.frame_cnt;
    o_red   = bus.red_detected;
  endtask

  task automatic disable_for(input int n);
    bus.enable = 1'b0;
    repeat (n) @(negedge clk);
    check("dis_red_hold", bus.red_detected, m_red);
    check("dis_last_hold", bus.last_count, m_last);
    check("dis_state", bus.fsm_state, 2'd0);
    bus.enable = 1'b1;
    m_hit  = 0;
    m_miss = 0;
    m_sync = 1'b1;
  endtask

  function automatic logic [16:0] rand_count();
    case ($urandom_range(0, 4))
      0:       return 17'($urandom_range(0, MINC - 1));
      1:       return 17'($urandom_range(MINC, LO - 1));
      2:       return 17'($urandom_range(LO, HI - 1));
      3:       return 17'($urandom_range(HI, SAT));
      default: return 17'($urandom_range(SAT + 1, 131071));
    endcase
  endfunction

  logic       o_valid, o_red;
  logic [7:0] o_frame;
  logic [3:0] o_thresh;

  initial begin
    // rows: count, auto_en, manual, exp valid, exp frame, exp red, exp thresh after sop
    tbl[0]  = '{17'd5000,  1'b0, 4'd10, 1'b0, 8'd0,  1'b0, 4'd10};
    tbl[1]  = '{17'd2500,  1'b0, 4'd10, 1'b1, 8'd1,  1'b0, 4'd10};
    tbl[2]  = '{17'd2500,  1'b0, 4'd10, 1'b1, 8'd2,  1'b0, 4'd10};
    tbl[3]  = '{17'd2500,  1'b0, 4'd10, 1'b1, 8'd3,  1'b1, 4'd10};
    tbl[4]  = '{17'd500,   1'b0, 4'd10, 1'b1, 8'd4,  1'b1, 4'd10};
    tbl[5]  = '{17'd500,   1'b0, 4'd10, 1'b1, 8'd5,  1'b1, 4'd10};
    tbl[6]  = '{17'd500,   1'b0, 4'd10, 1'b1, 8'd6,  1'b0, 4'd10};
    tbl[7]  = '{17'd2500,  1'b0, 4'd10, 1'b1, 8'd7,  1'b0, 4'd10};
    tbl[8]  = '{17'd1500,  1'b0, 4'd10, 1'b1, 8'd8,  1'b0, 4'd10};
    tbl[9]  = '{17'd2500,  1'b0, 4'd10, 1'b1, 8'd9,  1'b0, 4'd10};
    tbl[10] = '{17'd2500,  1'b0, 4'd10, 1'b1, 8'd10, 1'b0, 4'd10};
    tbl[11] = '{17'd2500,  1'b0, 4'd10, 1'b1, 8'd11, 1'b1, 4'd10};
    tbl[12] = '{17'd1000,  1'b0, 4'd10, 1'b1, 8'd12, 1'b1, 4'd10};
    tbl[13] = '{17'd1000,  1'b0, 4'd10, 1'b1, 8'd13, 1'b1, 4'd10};
    tbl[14] = '{17'd1000,  1'b0, 4'd10, 1'b1, 8'd14, 1'b1, 4'd10};
    tbl[15] = '{17'd1000,  1'b0, 4'd13, 1'b1, 8'd15, 1'b1, 4'd13};
    tbl[16] = '{17'd40000, 1'b1, 4'd13, 1'b1, 8'd16, 1'b1, 4'd13};
    tbl[17] = '{17'd40000, 1'b1, 4'd13, 1'b1, 8'd17, 1'b1, 4'd14};
    tbl[18] = '{17'd40000, 1'b1, 4'd13, 1'b1, 8'd18, 1'b1, 4'd15};
    tbl[19] = '{17'd40000, 1'b1, 4'd13, 1'b1, 8'd19, 1'b1, 4'd15};
    tbl[20] = '{17'd100,   1'b0, 4'd7,  1'b1, 8'd20, 1'b1, 4'd7};
    tbl[21] = '{17'd100,   1'b1, 4'd7,  1'b1, 8'd21, 1'b1, 4'd7};
    tbl[22] = '{17'd100,   1'b1, 4'd7,  1'b1, 8'd22, 1'b0, 4'd6};
    tbl[23] = '{17'd100,   1'b1, 4'd7,  1'b1, 8'd23, 1'b0, 4'd6};
    tbl[24] = '{17'd1000,  1'b0, 4'd3,  1'b1, 8'd24, 1'b0, 4'd3};

    // clock/reset
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.sop = 1'b0;
    bus.red_pixels = 17'd0;
    bus.auto_en = 1'b0;
    bus.thresh_manual = 4'd10;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_thresh", bus.upper_thresh, 4'd10);
    check("rst_red", bus.red_detected, 1'b0);
    check("rst_valid", bus.count_valid, 1'b0);
    check("rst_last", bus.last_count, 17'd0);
    check("rst_frame", bus.frame_cnt, 8'd0);
    check("rst_state", bus.fsm_state, 2'd0);
    reset = 1'b0;
    bus.enable = 1'b1;

    // directed table
    for (int i = 0; i < 25; i++) begin
      bus.auto_en = tbl[i].auto_en;
      bus.thresh_manual = tbl[i].manual;
      send_frame(tbl[i].count, 3, o_valid, o_frame, o_red, o_thresh);
      check("tbl_valid", o_valid, tbl[i].valid);
      check("tbl_frame", o_frame, tbl[i].frame);
      check("tbl_red", o_red, tbl[i].red);
      check("tbl_thresh", o_thresh, tbl[i].thresh);
    end

    // disable keeps red_detected and frame_cnt, discards the next sop
    for (int i = 0; i < 3; i++) send_frame(17'd2500, 3, o_valid, o_frame, o_red, o_thresh);
    check("pre_dis_red", o_red, 1'b1);
    disable_for(10);
    send_frame(17'd5000, 3, o_valid, o_frame, o_red, o_thresh);
    check("dis_discard", o_valid, 1'b0);
    check("dis_red_kept", o_red, 1'b1);
    send_frame(17'd1000, 3, o_valid, o_frame, o_red, o_thresh);
    check("dis_resume_valid", o_valid, 1'b1);
    check("dis_resume_frame", o_frame, 8'd28);

    // randomized frames against the model; long enough to wrap frame_cnt
    for (int i = 0; i < 280; i++) begin
      if ($urandom_range(0, 9) == 0) bus.auto_en = ~bus.auto_en;
      if (!bus.auto_en && $urandom_range(0, 3) == 0) bus.thresh_manual = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) disable_for($urandom_range(1, 12));
      send_frame(rand_count(), $urandom_range(2, 8), o_valid, o_frame, o_red, o_thresh);
    end

    // asynchronous reset in the middle of a frame
    bus.auto_en = 1'b0;
    bus.thresh_manual = 4'd12;
    for (int i = 0; i < 3; i++) send_frame(17'd2500, 3, o_valid, o_frame, o_red, o_thresh);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_thresh", bus.upper_thresh, 4'd10);
    check("arst_red", bus.red_detected, 1'b0);
    check("arst_last", bus.last_count, 17'd0);
    check("arst_frame", bus.frame_cnt, 8'd0);
    check("arst_state", bus.fsm_state, 2'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    send_frame(17'd5000, 3, o_valid, o_frame, o_red, o_thresh);
    check("arst_sync_discard", o_valid, 1'b0);
    check("arst_sync_thresh", o_thresh, 4'd12);
    send_frame(17'd2500, 3, o_valid, o_frame, o_red, o_thresh);
    check("arst_first_frame", o_frame, 8'd1);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/colour_frame_ctrl.md
Name: colour_frame_ctrl

Overview:
- Frame-level controller for the red-pixel colour detector.
- Samples the detector's per-frame red pixel count at each start-of-frame, applies hysteresis with consecutive-frame confirmation, and drives a debounced red_detected flag for the motion logic.
- Optionally auto-tunes the detector's red intensity threshold (upper_thresh) so that threshold changes land only on frame boundaries.

Parameters:
- HI_COUNT, 17'd2000: count at or above this is a "hit" frame.
- LO_COUNT, 17'd800: count below this is a "miss" frame; must be < HI_COUNT.
- N_CONFIRM, 3: consecutive hit or miss frames needed to set or clear red_detected (1..7).
- SAT_COUNT, 17'd30000: in auto mode, count above this raises the threshold.
- MIN_COUNT, 17'd200: in auto mode, count below this lowers the threshold.
- THRESH_MIN, 4'd6: auto-mode lower bound on the threshold.
- THRESH_INIT, 4'd10: threshold after reset.

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  controller run enable
- sop  in  1  start-of-frame pulse, shared with the detector
- red_pixels  in  17  detector count; holds the previous frame's total in the sop cycle
- auto_en  in  1  1 = auto threshold, 0 = manual
- thresh_manual  in  4  threshold used when auto_en = 0
- upper_thresh  out  4  threshold driven to the detector
- red_detected  out  1  debounced detection flag
- count_valid  out  1  one-cycle pulse when last_count updates
- last_count  out  17  most recently accepted frame count
- frame_cnt  out  8  accepted frames, wraps 255 -> 0

Behaviour:
- Reset values:
  - state = IDLE.
  - upper_thresh = THRESH_INIT; the pending threshold register is also THRESH_INIT.
  - red_detected, count_valid, last_count, frame_cnt, hit_run and miss_run are all 0.
- States:
  - IDLE: if enable = 1, go to SYNC.
  - SYNC: the first sop is a partial frame. Discard its sample, apply the pending threshold, go to MEASURE.
  - MEASURE: on sop, register red_pixels into last_count, apply the pending threshold to upper_thresh, go to EVAL.
  - EVAL: exactly one cycle.
    - Pulse count_valid.
    - Increment frame_cnt.
    - Update the run counters, red_detected and the pending threshold.
    - Return to MEASURE.
- enable = 0 in any state: go to IDLE next cycle. red_detected, last_count and upper_thresh hold; hit_run and miss_run clear.
- sop during EVAL is ignored. Frames are always much longer than 2 cycles, so this only matters for degenerate stimulus.
- Latency: count_valid and the updated red_detected appear 1 cycle after the sop edge that captured the sample.
- Hysteresis, using the c = last_count value registered at the sop:
  - c >= HI_COUNT: hit_run increments (saturates at 7), miss_run clears.
  - c < LO_COUNT: miss_run increments (saturates at 7), hit_run clears.
  - In between: both runs clear and red_detected holds.
  - red_detected sets when the incremented hit_run == N_CONFIRM, and clears when the incremented miss_run == N_CONFIRM.
- Threshold selection:
  - auto_en = 0: pending = thresh_manual.
  - auto_en = 1: if c > SAT_COUNT and pending < 15, pending + 1; else if c < MIN_COUNT and pending > THRESH_MIN, pending - 1; else hold.
  - When switching to auto, the pending value starts from the current upper_thresh.
- upper_thresh changes only in the cycle of an accepted sop (SYNC or MEASURE), so each frame is thresholded with a single value.
- All comparisons are unsigned on 17 bits.
- Asynchronous reset mid-frame returns to IDLE immediately. After reset release, the first sop after enable is treated as partial (SYNC).

Test Plan:
- Frame discard and capture: enable=1, auto_en=0, sop with red_pixels=5000, then sop with red_pixels=2500.
  - First sop: no count_valid.
  - Second sop: count_valid 1 cycle later, last_count=2500, frame_cnt=1.
- Hysteresis set: counts 2500, 2500, 2500 on 3 accepted frames -> red_detected rises after the 3rd.
  - Repeat with 2500, 1500, 2500, 2500, 2500 -> red_detected rises only after the 5th (1500 breaks the run).
- Hysteresis clear: with red_detected=1, counts 500, 500, 500 -> red_detected clears after the 3rd.
  - Counts of 1000 (between LO_COUNT and HI_COUNT) hold red_detected indefinitely.
- Auto threshold:
  - auto_en=1, four frames of 40000 from threshold 13 -> upper_thresh 14, 15, 15, 15.
  - Frames of 100 from 7 -> 6, then stays 6.
  - Every change occurs in a sop cycle.
- Manual override: auto_en=0, thresh_manual=4'd3 changed mid-frame -> upper_thresh stays old until the next accepted sop, then becomes 3 (no THRESH_MIN clamp).
- Reset and disable:
  - Assert reset mid-MEASURE -> all outputs return to reset values asynchronously.
  - enable=0 for 10 cycles then 1 -> next sop discarded, red_detected retained, frame_cnt continues.
  - 256 accepted frames wrap frame_cnt to 0.
